// File: rtl/debug_step_ctrl_if.sv
// Board-side bundle for debug_step_ctrl: raw keys and step-mode controls in,
// debounced key state, core clock enable and step counter out.
interface debug_step_ctrl_if #(
    parameter int unsigned NUM_KEYS = 3,
    parameter int unsigned BURST_W  = 8,
    parameter int unsigned STEP_W   = 16
);
    logic [NUM_KEYS-1:0] KEY;
    logic [1:0]          MODE;
    logic [BURST_W-1:0]  BURST_LEN;
    logic [NUM_KEYS-1:0] KEY_LEVEL;
    logic [NUM_KEYS-1:0] KEY_PRESS;
    logic                CPU_CLK_EN;
    logic                BUSY;
    logic [STEP_W-1:0]   STEP_CNT;

    modport master (
        output KEY, MODE, BURST_LEN,
        input  KEY_LEVEL, KEY_PRESS, CPU_CLK_EN, BUSY, STEP_CNT
    );

    modport slave (
        input  KEY, MODE, BURST_LEN,
        output KEY_LEVEL, KEY_PRESS, CPU_CLK_EN, BUSY, STEP_CNT
    );
endinterface

// File: rtl/debug_step_ctrl.sv
// Multi-key debouncer and CPU clock-enable generator: single-step, N-step burst
// and free-run stepping of the core, with stop, step-count clear and a step counter.
module debug_step_ctrl #(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 5000000,
    parameter int unsigned BURST_W         = 8,
    parameter int unsigned STEP_W          = 16
) (
    input logic               CLK,
    input logic               RST,
    debug_step_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned DIV_W = $clog2(RUN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    logic [NUM_KEYS-1:0]            r_sync1;
    logic [NUM_KEYS-1:0]            r_sync2;
    logic [NUM_KEYS-1:0][CNT_W-1:0] r_db_cnt;
    logic [NUM_KEYS-1:0]            r_key_level;
    logic [NUM_KEYS-1:0]            r_key_press;
    state_t                         r_state;
    logic [DIV_W-1:0]               r_div;
    logic [BURST_W-1:0]             r_remain;
    logic                           r_en;
    logic                           r_busy;
    logic [STEP_W-1:0]              r_step_cnt;

    logic [NUM_KEYS-1:0]            w_key_s;
    logic [NUM_KEYS-1:0][CNT_W-1:0] w_db_cnt_next;
    logic [NUM_KEYS-1:0]            w_level_next;
    logic [NUM_KEYS-1:0]            w_press_next;
    state_t                         w_state_next;
    logic [DIV_W-1:0]               w_div_next;
    logic [BURST_W-1:0]             w_remain_next;
    logic                           w_single_step;
    logic                           w_en_next;
    logic [STEP_W-1:0]              w_step_cnt_next;

    assign w_key_s = ~r_sync2;

    // Per-key debounce: a new level needs DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        w_level_next  = r_key_level;
        w_press_next  = '0;
        w_db_cnt_next = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (w_key_s[i] != r_key_level[i]) begin
                if (r_db_cnt[i] == CNT_MAX) begin
                    w_level_next[i] = w_key_s[i];
                    w_press_next[i] = w_key_s[i];
                end else begin
                    w_db_cnt_next[i] = r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Step FSM next-state; stop (KEY_PRESS[1]) beats start and any pending pulse.
    always_comb begin
        w_state_next  = r_state;
        w_div_next    = r_div;
        w_remain_next = r_remain;
        w_single_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_key_press[0] && !r_key_press[1]) begin
                    case (bus.MODE)
                        2'b00: w_single_step = 1'b1;
                        2'b01: begin
                            if (bus.BURST_LEN != '0) begin
                                w_state_next  = ST_BURST;
                                w_remain_next = bus.BURST_LEN;
                                w_div_next    = '0;
                            end
                        end
                        2'b10: begin
                            w_state_next = ST_RUN;
                            w_div_next   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BURST: begin
                if (r_key_press[1]) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_div_next = (r_div == DIV_MAX) ? '0 : r_div + DIV_W'(1);
                    if (r_en) begin
                        w_remain_next = r_remain - BURST_W'(1);
                        if (r_remain == BURST_W'(1)) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (r_key_press[1]) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_div_next = (r_div == DIV_MAX) ? '0 : r_div + DIV_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Divider pulse is registered a cycle ahead, so look at next-cycle stop press.
        w_en_next = w_single_step
                  || ((w_state_next != ST_IDLE) && (w_div_next == DIV_MAX) && !w_press_next[1]);

        if (r_key_press[2]) begin
            w_step_cnt_next = '0;
        end else if (r_en) begin
            w_step_cnt_next = r_step_cnt + STEP_W'(1);
        end else begin
            w_step_cnt_next = r_step_cnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_db_cnt    <= '0;
            r_key_level <= '0;
            r_key_press <= '0;
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_remain    <= '0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_step_cnt  <= '0;
        end else begin
            r_sync1     <= bus.KEY;
            r_sync2     <= r_sync1;
            r_db_cnt    <= w_db_cnt_next;
            r_key_level <= w_level_next;
            r_key_press <= w_press_next;
            r_state     <= w_state_next;
            r_div       <= w_div_next;
            r_remain    <= w_remain_next;
            r_en        <= w_en_next;
            r_busy      <= (w_state_next != ST_IDLE);
            r_step_cnt  <= w_step_cnt_next;
        end
    end

    assign bus.KEY_LEVEL  = r_key_level;
    assign bus.KEY_PRESS  = r_key_press;
    assign bus.CPU_CLK_EN = r_en;
    assign bus.BUSY       = r_busy;
    assign bus.STEP_CNT   = r_step_cnt;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed bench for debug_step_ctrl with short debounce/divider settings and
// hand-computed cycle-exact expectations.
module tb_debug_step_ctrl;
    localparam int unsigned NK  = 3;
    localparam int unsigned BW  = 8;
    localparam int unsigned SW  = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    debug_step_ctrl_if #(.NUM_KEYS(NK), .BURST_W(BW), .STEP_W(SW)) bus ();

    debug_step_ctrl #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(4), .RUN_DIV(3), .BURST_W(BW), .STEP_W(SW)
    ) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pull key k low and advance to the cycle its debounced press pulse is visible.
    task automatic press_to_t(input int k);
        bus.KEY[k] = 1'b0;
        repeat (5) tick();
        chk("pre_press_level", 32'(bus.KEY_LEVEL[k]), 32'd0);
        tick();
        chk("press_pulse", 32'(bus.KEY_PRESS[k]), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.KEY       = '1;
        bus.MODE      = 2'b11;
        bus.BURST_LEN = '0;

        // Reset values
        repeat (2) tick();
        chk("rst_level", 32'(bus.KEY_LEVEL), 32'd0);
        chk("rst_press", 32'(bus.KEY_PRESS), 32'd0);
        chk("rst_en", 32'(bus.CPU_CLK_EN), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_cnt", 32'(bus.STEP_CNT), 32'd0);
        rst = 1'b1;
        tick();

        // 1: 3-cycle glitch ignored; real press lands 6 cycles after the pin falls
        bus.KEY[0] = 1'b0;
        repeat (3) tick();
        bus.KEY[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_level_press", {26'd0, bus.KEY_LEVEL, bus.KEY_PRESS}, 32'd0);
        end
        bus.KEY[0] = 1'b0;
        repeat (5) tick();
        chk("lat_level_c5", 32'(bus.KEY_LEVEL[0]), 32'd0);
        tick();
        chk("lat_level_c6", 32'(bus.KEY_LEVEL[0]), 32'd1);
        chk("lat_press_c6", 32'(bus.KEY_PRESS), 32'b001);
        tick();
        chk("press_single", 32'(bus.KEY_PRESS), 32'd0);
        chk("hold_no_step", {30'd0, bus.CPU_CLK_EN, bus.BUSY}, 32'd0);
        repeat (3) tick();
        bus.KEY[0] = 1'b1;
        repeat (8) tick();
        chk("release_level", 32'(bus.KEY_LEVEL), 32'd0);

        // 2: single-step, three presses
        bus.MODE = 2'b00;
        for (int n = 0; n < 3; n++) begin
            press_to_t(0);
            chk("ss_en_t", 32'(bus.CPU_CLK_EN), 32'd0);
            bus.KEY[0] = 1'b1;
            tick();
            chk("ss_en_t1", 32'(bus.CPU_CLK_EN), 32'd1);
            chk("ss_busy", 32'(bus.BUSY), 32'd0);
            tick();
            chk("ss_en_t2", 32'(bus.CPU_CLK_EN), 32'd0);
            repeat (8) tick();
        end
        chk("ss_cnt", 32'(bus.STEP_CNT), 32'd3);

        // 3: burst of 5 then burst of 0
        bus.MODE      = 2'b01;
        bus.BURST_LEN = 8'd5;
        press_to_t(0);
        bus.KEY[0] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("b5_en", 32'(bus.CPU_CLK_EN), (c % 3 == 0 && c <= 15) ? 32'd1 : 32'd0);
            chk("b5_busy", 32'(bus.BUSY), (c <= 15) ? 32'd1 : 32'd0);
        end
        chk("b5_cnt", 32'(bus.STEP_CNT), 32'd8);
        bus.BURST_LEN = 8'd0;
        press_to_t(0);
        bus.KEY[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("b0_en_busy", {30'd0, bus.CPU_CLK_EN, bus.BUSY}, 32'd0);
        end
        chk("b0_cnt", 32'(bus.STEP_CNT), 32'd8);

        // 5: MODE change and start press during burst ignored; clear beats enable
        bus.BURST_LEN = 8'd6;
        press_to_t(0);
        bus.KEY[0] = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk("b6_en", 32'(bus.CPU_CLK_EN), (c % 3 == 0 && c <= 18) ? 32'd1 : 32'd0);
            chk("b6_busy", 32'(bus.BUSY), (c <= 18) ? 32'd1 : 32'd0);
            if (c == 1) bus.MODE = 2'b10;
            if (c == 6) begin
                chk("b6_rel_level", 32'(bus.KEY_LEVEL[0]), 32'd0);
                bus.KEY[0] = 1'b0;
            end
            if (c == 9) bus.KEY[2] = 1'b0;
            if (c == 12) begin
                chk("b6_start_in_burst", 32'(bus.KEY_PRESS[0]), 32'd1);
                bus.KEY[0] = 1'b1;
            end
            if (c == 15) begin
                chk("b6_clr_press", 32'(bus.KEY_PRESS[2]), 32'd1);
                chk("b6_cnt_pre_clr", 32'(bus.STEP_CNT), 32'd12);
                bus.KEY[2] = 1'b1;
            end
            if (c == 16) chk("b6_cnt_clr", 32'(bus.STEP_CNT), 32'd0);
            if (c == 19) chk("b6_cnt_end", 32'(bus.STEP_CNT), 32'd1);
        end
        repeat (4) tick();

        // 4: clear in IDLE, free-run 20 steps with wrap, stop on a pulse cycle
        press_to_t(2);
        bus.KEY[2] = 1'b1;
        tick();
        chk("idle_clr", 32'(bus.STEP_CNT), 32'd0);
        repeat (8) tick();
        press_to_t(0);
        bus.KEY[0] = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            tick();
            chk("run_en", 32'(bus.CPU_CLK_EN), (c % 3 == 0 && c < 63) ? 32'd1 : 32'd0);
            chk("run_busy", 32'(bus.BUSY), (c <= 63) ? 32'd1 : 32'd0);
            if (c == 49) chk("run_wrap", 32'(bus.STEP_CNT), 32'd0);
            if (c == 57) bus.KEY[1] = 1'b0;
            if (c == 61) chk("run_cnt20", 32'(bus.STEP_CNT), 32'd4);
            if (c == 63) begin
                chk("run_stop_press", 32'(bus.KEY_PRESS[1]), 32'd1);
                bus.KEY[1] = 1'b1;
            end
            if (c == 64) chk("run_cnt_after", 32'(bus.STEP_CNT), 32'd4);
        end
        repeat (8) tick();

        // 6: reset mid-run with KEY[0] held through reset
        press_to_t(0);
        repeat (4) tick();
        chk("r6_busy", 32'(bus.BUSY), 32'd1);
        chk("r6_cnt", 32'(bus.STEP_CNT), 32'd5);
        rst = 1'b0;
        tick();
        chk("r6_rst_outs", {25'd0, bus.KEY_LEVEL, bus.KEY_PRESS, bus.CPU_CLK_EN}, 32'd0);
        chk("r6_rst_busy", 32'(bus.BUSY), 32'd0);
        chk("r6_rst_cnt", 32'(bus.STEP_CNT), 32'd0);
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("r6_quiet", {27'd0, bus.KEY_PRESS, bus.CPU_CLK_EN, bus.BUSY}, 32'd0);
        end
        tick();
        chk("r6_press", 32'(bus.KEY_PRESS), 32'b001);
        chk("r6_level", 32'(bus.KEY_LEVEL), 32'b001);
        tick();
        chk("r6_run_en", 32'(bus.CPU_CLK_EN), 32'd0);
        chk("r6_run_busy", 32'(bus.BUSY), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_step_ctrl.md
Name: debug_step_ctrl

Overview:
Parametrised multi-key debouncer and CPU clock-enable generator for board-level bring-up of the single-cycle RISC-V core. It replaces a single-switch debounced manual clock with three step modes: single-step, N-step burst and free-run, plus stop and step-count clear. It sits between the DE10-Lite push buttons and the core's clock enable, and exports a step counter for the 7-segment display.

Parameters:
NUM_KEYS, 3, number of raw push-button inputs; must be >= 3 (KEY[0]=start/step, KEY[1]=stop, KEY[2]=clear counter, higher keys are debounce-only)
DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a new key level (10 ms at 50 MHz); must be >= 2
RUN_DIV, 5000000, CLK cycles per generated step in burst and run modes; must be >= 2
BURST_W, 8, width of the burst length input
STEP_W, 16, width of the step counter

Ports:
CLK  input  1  system clock (50 MHz board clock)
RST  input  1  synchronous, active-low reset
KEY  input  NUM_KEYS  raw push buttons, active-low (0 = pressed), asynchronous to CLK
MODE  input  2  00 single-step, 01 burst, 10 free-run, 11 hold (start ignored)
BURST_LEN  input  BURST_W  number of steps issued per burst
KEY_LEVEL  output  NUM_KEYS  debounced key state, active-high (1 = pressed)
KEY_PRESS  output  NUM_KEYS  one-cycle pulse on each debounced press (0->1 of KEY_LEVEL)
CPU_CLK_EN  output  1  one-cycle step enable for the core
BUSY  output  1  high while in BURST or RUN
STEP_CNT  output  STEP_W  number of CPU_CLK_EN pulses since the last clear or reset

Behaviour:
- Reset (RST=0 at a CLK edge): 2-FF synchronisers preset to 1 (released), debounce counters 0, KEY_LEVEL=0, KEY_PRESS=0, CPU_CLK_EN=0, BUSY=0, STEP_CNT=0, state=IDLE, divider=0, remaining=0. Reset mid-burst or mid-run aborts immediately; no pulse is issued in the reset cycle.
- Synchroniser: per key, two flops; s = ~sync2 (active-high pressed).
- Debounce, per key, independent:
  - if s == KEY_LEVEL: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: KEY_LEVEL <= s, cnt <= 0.
  - else cnt++.
  - A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples. Pin-to-KEY_LEVEL latency is 2 + DEBOUNCE_CYCLES cycles. Any glitch shorter than DEBOUNCE_CYCLES is ignored.
- KEY_PRESS[i] is registered and high in the first cycle that KEY_LEVEL[i] reads 1. Releases produce no pulse.
- Mode is sampled only on KEY_PRESS[0] in IDLE. MODE changes during BURST/RUN have no effect.
- FSM, decisions made in the cycle KEY_PRESS is high (call it t):
  - IDLE, KEY_PRESS[0], MODE=00: CPU_CLK_EN=1 in cycle t+1; stay IDLE.
  - IDLE, KEY_PRESS[0], MODE=01, BURST_LEN!=0: remaining <= BURST_LEN, divider <= 0; BURST from t+1.
  - IDLE, KEY_PRESS[0], MODE=01, BURST_LEN==0: no action.
  - IDLE, KEY_PRESS[0], MODE=10: divider <= 0; RUN from t+1.
  - IDLE, KEY_PRESS[0], MODE=11: no action.
  - IDLE, KEY_PRESS[0] and KEY_PRESS[1] in the same cycle: stop wins, no action.
  - BURST: divider counts 0..RUN_DIV-1 and wraps. CPU_CLK_EN=1 in the cycle divider==RUN_DIV-1, so the first pulse falls at t+RUN_DIV. Each pulse decrements remaining; the pulse that drives remaining to 0 also returns the FSM to IDLE for the next cycle.
  - RUN: same divider pulse timing; runs indefinitely.
  - BURST/RUN, KEY_PRESS[1]: go to IDLE next cycle. If the divider would pulse in that same cycle, the pulse is suppressed (stop has priority).
  - BURST/RUN, KEY_PRESS[0]: ignored.
- BUSY = (state != IDLE), registered with the state.
- STEP_CNT: +1 on each CPU_CLK_EN, wrapping from all-ones to 0. KEY_PRESS[2] clears it to 0 in the next cycle. If a clear and an enable occur in the same cycle, the clear wins and the result is 0.
- CPU_CLK_EN is never high for two consecutive cycles.

Test Plan:
Use DEBOUNCE_CYCLES=4, RUN_DIV=3, BURST_W=8, STEP_W=4 for simulation.
1. Hold KEY[0]=0 for 3 cycles, then release -> no KEY_LEVEL/KEY_PRESS change. Hold for 10 cycles -> KEY_LEVEL[0] rises exactly 6 cycles after the pin falls, with a single KEY_PRESS[0] pulse.
2. MODE=00, three debounced presses of KEY[0] -> exactly three single-cycle CPU_CLK_EN pulses, each one cycle after its KEY_PRESS[0]; STEP_CNT=3; BUSY stays 0.
3. MODE=01, BURST_LEN=5, press KEY[0] at t -> pulses at t+3, t+6, t+9, t+12, t+15; BUSY falls at t+16; STEP_CNT=5. Repeat with BURST_LEN=0 -> no pulses, BUSY stays 0.
4. MODE=10, press KEY[0], let 20 steps run -> STEP_CNT wraps 15->0 and reads 4. Press KEY[1] so KEY_PRESS[1] coincides with a divider pulse cycle -> that pulse is suppressed and BUSY=0 next cycle.
5. During a burst, change MODE and press KEY[0] -> burst continues unchanged. Press KEY[2] coincident with a CPU_CLK_EN -> STEP_CNT=0.
6. Assert RST=0 mid-RUN for one cycle -> all outputs return to reset values and no CPU_CLK_EN appears. Keep KEY[0] held through reset -> a KEY_PRESS[0] pulse follows DEBOUNCE_CYCLES+2 cycles after reset release.
